// File: rtl/if_prefetch.sv
// Instruction-fetch stage: generates the fetch PC, keeps at most one memory read in flight,
// and buffers returned instructions with their PC+4 in a small queue that feeds decode.
module if_prefetch #(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              JR_SHIFT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              branch_sel,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              jump_reg,
    input  logic [ADDR_W-1:0] jr_value,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] instruction,
    output logic [ADDR_W-1:0] inst_pc4,
    output logic [ADDR_W-1:0] pc_probe
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_req_pc;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [DATA_W-1:0] r_q_data [DEPTH];
    logic [ADDR_W-1:0] r_q_pc4  [DEPTH];

    logic              w_redirect;
    logic [ADDR_W-1:0] w_target;
    logic              w_issue;
    logic              w_push;
    logic              w_pop;

    // Jump-register outranks jump, which outranks a taken branch.
    always_comb begin
        w_target = branch_target;
        if (jump_reg) begin
            w_target = jr_value << JR_SHIFT;
        end else if (jump) begin
            w_target = jump_target;
        end
    end

    assign w_redirect = branch_sel | jump | jump_reg;

    // A request reserves a queue slot up front, so a returning response always has room.
    assign imem_req  = reset && (r_state == S_IDLE) && (r_count < CNT_W'(DEPTH)) && !w_redirect;
    assign imem_addr = r_fetch_pc;
    assign pc_probe  = r_fetch_pc;
    assign w_issue   = imem_req && imem_ready;
    assign w_push    = (r_state == S_WAIT) && imem_rvalid && !w_redirect;

    assign inst_valid  = (r_count != '0);
    assign w_pop       = inst_valid && inst_ready;
    assign instruction = inst_valid ? r_q_data[r_rd_ptr] : '0;
    assign inst_pc4    = inst_valid ? r_q_pc4[r_rd_ptr]  : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_pc   <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_data[i] <= '0;
                r_q_pc4[i]  <= '0;
            end
        end else begin
            // A redirect while a read is outstanding turns that read into one whose data is dropped.
            case (r_state)
                S_IDLE: begin
                    if (w_issue) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) r_state <= S_IDLE;
                    else if (w_redirect) r_state <= S_DISCARD;
                end
                S_DISCARD: begin
                    if (imem_rvalid) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_issue) r_req_pc <= r_fetch_pc;

            if (w_redirect) begin
                r_fetch_pc <= w_target;
            end else if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
            end

            // A pop coinciding with a redirect still completes; everything behind it is flushed.
            if (w_redirect) begin
                r_count  <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_q_data[r_wr_ptr] <= imem_rdata;
                    r_q_pc4[r_wr_ptr]  <= r_req_pc + ADDR_W'(4);
                    r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: a variable-latency memory stub plus a queue-based model of the
// fetch stage's visible behaviour, compared against the design every cycle.
module tb_if_prefetch;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0;

    logic          clk;
    logic          reset;
    logic          branch_sel;
    logic [AW-1:0] branch_target;
    logic          jump;
    logic [AW-1:0] jump_target;
    logic          jump_reg;
    logic [AW-1:0] jr_value;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ready;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic          inst_valid;
    logic          inst_ready;
    logic [DW-1:0] instruction;
    logic [AW-1:0] inst_pc4;
    logic [AW-1:0] pc_probe;

    if_prefetch #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(RPC), .JR_SHIFT(2)
    ) dut (
        .clk(clk), .reset(reset),
        .branch_sel(branch_sel), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .jump_reg(jump_reg), .jr_value(jr_value),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .instruction(instruction), .inst_pc4(inst_pc4), .pc_probe(pc_probe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: fetch PC, the one outstanding read (and whether it is still wanted), the queue.
    logic [31:0] mPc;
    logic        mPend;
    logic        mKeep;
    logic [31:0] mPendAddr;
    logic [31:0] qData[$];
    logic [31:0] qPc4[$];

    // Memory stub state.
    logic        memBusy = 1'b0;
    int          memCnt  = 0;
    int          memLat  = 1;
    logic [31:0] memAddr = '0;
    int          hsCount = 0;

    logic        expReq;
    logic        expValid;
    logic [31:0] expAddr;
    logic [31:0] expInst;
    logic [31:0] expPc4;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0FF_EE11;
    endfunction

    // Drive one cycle's inputs (memory response included) and predict the visible outputs.
    task automatic setInputs(input logic rst, input logic jr, input logic jp, input logic br,
                             input logic [31:0] jrv, input logic [31:0] jt, input logic [31:0] bt,
                             input logic rdy, input logic mrdy, input logic spur);
        reset         = rst;
        jump_reg      = jr;
        jump          = jp;
        branch_sel    = br;
        jr_value      = jrv;
        jump_target   = jt;
        branch_target = bt;
        inst_ready    = rdy;
        imem_ready    = mrdy;
        imem_rvalid   = 1'b0;
        imem_rdata    = $urandom;
        if (memBusy && memCnt == 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memWord(memAddr);
        end else if (!memBusy && spur) begin
            imem_rvalid = 1'b1;
        end
        #1;
        expReq   = rst && !mPend && (qData.size() < DEPTH) && !(jr | jp | br);
        expAddr  = mPc;
        expValid = (qData.size() != 0);
        expInst  = expValid ? qData[0] : 32'h0;
        expPc4   = expValid ? qPc4[0]  : 32'h0;
    endtask

    // Advance the model and memory stub across one rising edge, then move to the falling edge.
    task automatic tick();
        logic        redir;
        logic [31:0] tgt;
        logic        hs;
        logic        pop;
        logic        dutHs;
        redir = jump_reg | jump | branch_sel;
        tgt   = jump_reg ? (jr_value << 2) : (jump ? jump_target : branch_target);
        hs    = expReq && imem_ready;
        pop   = expValid && inst_ready;
        dutHs = imem_req && imem_ready;
        if (!reset) begin
            mPc   = RPC;
            mPend = 1'b0;
            mKeep = 1'b0;
            qData.delete();
            qPc4.delete();
        end else begin
            if (pop) begin
                void'(qData.pop_front());
                void'(qPc4.pop_front());
            end
            if (mPend && imem_rvalid) begin
                if (mKeep && !redir) begin
                    qData.push_back(imem_rdata);
                    qPc4.push_back(mPendAddr + 32'd4);
                end
                mPend = 1'b0;
            end else if (mPend && redir) begin
                mKeep = 1'b0;
            end
            if (redir) begin
                qData.delete();
                qPc4.delete();
            end
            if (hs) begin
                mPend     = 1'b1;
                mKeep     = 1'b1;
                mPendAddr = mPc;
                mPc       = mPc + 32'd4;
            end
            if (redir) mPc = tgt;
        end
        if (!reset) begin
            memBusy = 1'b0;
        end else if (memBusy) begin
            if (imem_rvalid) memBusy = 1'b0;
            else memCnt--;
        end else if (dutHs) begin
            memBusy = 1'b1;
            memCnt  = memLat;
            memAddr = imem_addr;
        end
        if (dutHs) hsCount++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic doReset();
        for (int i = 0; i < 2; i++) begin
            setInputs(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            tick();
        end
        hsCount = 0;
    endtask

    task automatic test_reset();
        memLat = 1;
        doReset();
        setInputs(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_req: got %b expected 0", imem_req);
        end
        checks++;
        if ({inst_valid, instruction, inst_pc4} !== {1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL reset_queue: got v=%b inst=%h pc4=%h expected 0/0/0", inst_valid, instruction, inst_pc4);
        end
        checks++;
        if (pc_probe !== RPC) begin
            errors++;
            $display("[TB] FAIL reset_pc: got %h expected %h", pc_probe, RPC);
        end
        tick();
        setInputs(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, RPC}) begin
            errors++;
            $display("[TB] FAIL reset_first_req: got req=%b addr=%h expected 1/%h", imem_req, imem_addr, RPC);
        end
        tick();
    endtask

    task automatic test_free_run();
        logic [31:0] addrs[$];
        logic [31:0] pcs[$];
        logic [31:0] insts[$];
        memLat = 1;
        doReset();
        for (int i = 0; i < 24; i++) begin
            setInputs(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
            checks++;
            if ({imem_req, imem_addr, inst_valid, instruction, inst_pc4, pc_probe} !==
                {expReq, expAddr, expValid, expInst, expPc4, expAddr}) begin
                errors++;
                $display("[TB] FAIL free_run_cyc%0d: got %h expected %h", i,
                         {imem_req, imem_addr, inst_valid, instruction, inst_pc4, pc_probe},
                         {expReq, expAddr, expValid, expInst, expPc4, expAddr});
            end
            if (imem_req && imem_ready) addrs.push_back(imem_addr);
            if (inst_valid && inst_ready) begin
                pcs.push_back(inst_pc4);
                insts.push_back(instruction);
            end
            tick();
        end
        checks++;
        if (addrs.size() < 8 || pcs.size() < 8) begin
            errors++;
            $display("[TB] FAIL free_run_count: got %0d reqs %0d pops expected at least 8 each", addrs.size(), pcs.size());
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if ({addrs[k], pcs[k], insts[k]} !== {32'(4 * k), 32'(4 * k + 4), memWord(32'(4 * k))}) begin
                    errors++;
                    $display("[TB] FAIL free_run_seq%0d: got addr=%h pc4=%h inst=%h expected %h/%h/%h", k,
                             addrs[k], pcs[k], insts[k], 32'(4 * k), 32'(4 * k + 4), memWord(32'(4 * k)));
                end
            end
        end
    endtask

    task automatic test_full_queue();
        logic [31:0] pops[$];
        logic [31:0] firstAddr;
        logic        seen;
        memLat = 1;
        doReset();
        for (int i = 0; i < 20; i++) begin
            setInputs(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            checks++;
            if ({imem_req, imem_addr, inst_valid, instruction, inst_pc4, pc_probe} !==
                {expReq, expAddr, expValid, expInst, expPc4, expAddr}) begin
                errors++;
                $display("[TB] FAIL full_fill_cyc%0d: got %h expected %h", i,
                         {imem_req, imem_addr, inst_valid, instruction, inst_pc4, pc_probe},
                         {expReq, expAddr, expValid, expInst, expPc4, expAddr});
            end
            tick();
        end
        checks++;
        if (hsCount !== 4) begin
            errors++;
            $display("[TB] FAIL full_req_count: got %0d expected 4", hsCount);
        end
        seen = 1'b0;
        firstAddr = '0;
        for (int i = 0; i < 6; i++) begin
            setInputs(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
            if (i == 0) begin
                checks++;
                if ({imem_req, inst_valid} !== 2'b01) begin
                    errors++;
                    $display("[TB] FAIL full_stalled: got req=%b valid=%b expected 0/1", imem_req, inst_valid);
                end
            end
            if (inst_valid && inst_ready) pops.push_back(inst_pc4);
            if (imem_req && imem_ready && !seen) begin
                seen = 1'b1;
                firstAddr = imem_addr;
            end
            tick();
        end
        checks++;
        if (!seen || firstAddr !== 32'd16) begin
            errors++;
            $display("[TB] FAIL full_resume_addr: got seen=%b addr=%h expected 1/00000010", seen, firstAddr);
        end
        checks++;
        if (pops.size() < 4) begin
            errors++;
            $display("[TB] FAIL full_pop_count: got %0d expected at least 4", pops.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (pops[k] !== 32'(4 * k + 4)) begin
                    errors++;
                    $display("[TB] FAIL full_pop%0d: got %h expected %h", k, pops[k], 32'(4 * k + 4));
                end
            end
        end
    endtask

    task automatic test_branch_wait();
        memLat = 3;
        doReset();
        setInputs(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        tick();
        setInputs(1, 0, 0, 1, 0, 0, 32'h100, 1, 1, 0);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL branch_blocks_req: got %b expected 0", imem_req);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            setInputs(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
            checks++;
            if ({imem_req, inst_valid} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL branch_discard%0d: got req=%b valid=%b expected 0/0", i, imem_req, inst_valid);
            end
            tick();
        end
        setInputs(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        checks++;
        if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h100, 1'b0}) begin
            errors++;
            $display("[TB] FAIL branch_next_req: got req=%b addr=%h valid=%b expected 1/00000100/0", imem_req, imem_addr, inst_valid);
        end
        tick();
    endtask

    task automatic test_priority();
        memLat = 1;
        doReset();
        setInputs(1, 1, 1, 1, 32'h40, 32'h200, 32'h300, 1, 1, 0);
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prio_blocks_req: got %b expected 0", imem_req);
        end
        tick();
        setInputs(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
            errors++;
            $display("[TB] FAIL prio_target: got req=%b addr=%h expected 1/00000100", imem_req, imem_addr);
        end
        tick();
        setInputs(1, 0, 1, 1, 0, 32'h200, 32'h300, 1, 1, 0);
        tick();
        setInputs(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        checks++;
        if (pc_probe !== 32'h200) begin
            errors++;
            $display("[TB] FAIL prio_jump_over_branch: got %h expected 00000200", pc_probe);
        end
        tick();
    endtask

    task automatic test_redirect_pop_rvalid();
        logic ready;
        memLat = 2;
        doReset();
        ready = 1'b0;
        for (int i = 0; i < 40 && !ready; i++) begin
            if (qData.size() >= 2 && memBusy && memCnt == 1) begin
                ready = 1'b1;
            end else begin
                setInputs(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
                tick();
            end
        end
        checks++;
        if (!ready) begin
            errors++;
            $display("[TB] FAIL rpr_setup: got no response window expected one within 40 cycles");
        end else begin
            setInputs(1, 0, 1, 0, 0, 32'h500, 0, 1, 1, 0);
            checks++;
            if ({inst_valid, inst_pc4, instruction} !== {1'b1, 32'h4, memWord(32'h0)}) begin
                errors++;
                $display("[TB] FAIL rpr_popped_head: got v=%b pc4=%h inst=%h expected 1/00000004/%h",
                         inst_valid, inst_pc4, instruction, memWord(32'h0));
            end
            tick();
            setInputs(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            checks++;
            if ({inst_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h500}) begin
                errors++;
                $display("[TB] FAIL rpr_after: got v=%b req=%b addr=%h expected 0/1/00000500", inst_valid, imem_req, imem_addr);
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        memLat = 1;
        doReset();
        setInputs(1, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 0, 1, 0);
        tick();
        setInputs(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            errors++;
            $display("[TB] FAIL wrap_req: got req=%b addr=%h expected 1/fffffffc", imem_req, imem_addr);
        end
        tick();
        setInputs(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if (pc_probe !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wrap_pc: got %h expected 00000000", pc_probe);
        end
        tick();
        setInputs(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++;
        if ({inst_valid, inst_pc4, instruction} !== {1'b1, 32'h0, memWord(32'hFFFF_FFFC)}) begin
            errors++;
            $display("[TB] FAIL wrap_entry: got v=%b pc4=%h inst=%h expected 1/00000000/%h",
                     inst_valid, inst_pc4, instruction, memWord(32'hFFFF_FFFC));
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        memLat = 3;
        doReset();
        setInputs(1, 0, 0, 1, 0, 0, 32'h80, 1, 1, 0);
        tick();
        setInputs(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        tick();
        setInputs(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        tick();
        setInputs(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        checks++;
        if ({imem_req, imem_addr, inst_valid} !== {1'b1, RPC, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_mid_wait: got req=%b addr=%h v=%b expected 1/%h/0", imem_req, imem_addr, inst_valid, RPC);
        end
        tick();
    endtask

    task automatic test_random();
        logic        rst;
        logic        jr;
        logic        jp;
        logic        br;
        logic [31:0] jrv;
        logic [31:0] jt;
        logic [31:0] bt;
        doReset();
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 99) != 0);
            jr     = ($urandom_range(0, 19) == 0);
            jp     = ($urandom_range(0, 15) == 0);
            br     = ($urandom_range(0, 11) == 0);
            jrv    = $urandom;
            jt     = $urandom & 32'hFFFF_FFFC;
            bt     = $urandom & 32'hFFFF_FFFC;
            memLat = $urandom_range(1, 4);
            setInputs(rst, jr, jp, br, jrv, jt, bt, 1'($urandom_range(0, 2) != 0),
                      1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
            checks++;
            if ({imem_req, imem_addr, inst_valid, instruction, inst_pc4, pc_probe} !==
                {expReq, expAddr, expValid, expInst, expPc4, expAddr}) begin
                errors++;
                $display("[TB] FAIL random_cyc%0d: got %h expected %h", i,
                         {imem_req, imem_addr, inst_valid, instruction, inst_pc4, pc_probe},
                         {expReq, expAddr, expValid, expInst, expPc4, expAddr});
            end
            tick();
        end
    endtask

    initial begin
        mPc   = RPC;
        mPend = 1'b0;
        mKeep = 1'b0;
        test_reset();
        test_free_run();
        test_full_queue();
        test_branch_wait();
        test_priority();
        test_redirect_pop_rvalid();
        test_wrap();
        test_reset_mid_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: got no completion expected finish before 500000");
        $fatal(1, "[TB] timeout");
    end

endmodule
